reg_write_arbiter: RTL and testbench
====================================

Name: reg_write_arbiter

Overview:
- Shares the single write path into the 8 x 16-bit register block between NREQ writeback requesters (ALU, load unit, immediate/move path) using round-robin arbitration with a valid/ready handshake.
- The register block reloads D on every clock, so this block drives all eight D inputs. Each D input carries the register's current Q, except for the one register being written that cycle.
- Writes pass through one registered stage. The block also exports a pending-write mask for hazard checks in the issue logic.

Parameters:
- NREQ, 3, number of write requesters; port index 0 = ALU, 1 = load, 2 = imm.
- NREGS, 8, number of registers in the block.
- WIDTH, 16, register data width.
- AW, 3, register address width; must equal clog2(NREGS).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NREQ  per-requester write request.
- req_addr  in  NREQ*AW  packed target register index; requester i at bits [i*AW +: AW].
- req_data  in  NREQ*WIDTH  packed write data; requester i at bits [i*WIDTH +: WIDTH].
- req_ready  out  NREQ  one-hot grant; the write is accepted when valid & ready.
- reg_q  in  NREGS*WIDTH  packed Q outputs of the register block (r1 at LSBs).
- reg_d  out  NREGS*WIDTH  packed D inputs to the register block.
- pend_mask  out  NREGS  bit k = 1 while a write to register k sits in the write stage.
- wr_busy  out  1  write stage valid.

Behaviour:
- Reset (async, rst=1):
  - Stage valid, addr and data go to 0; round-robin pointer goes to 0.
  - Outputs: req_ready=0, pend_mask=0, wr_busy=0, reg_d=reg_q (pass-through; the register block's own reset dominates).
- Arbitration (combinational on req_valid and pointer):
  - Search starts at index ptr and proceeds ptr, ptr+1, … modulo NREQ. The first valid requester is granted.
  - req_ready is one-hot for that requester, or all zero if no requester is valid.
  - req_ready must not depend on req_addr or req_data.
- Acceptance:
  - Exactly one grant per cycle; the write stage accepts every cycle, so there is no backpressure beyond arbitration.
  - On a granted edge: stage_valid←1, stage_addr←req_addr[g], stage_data←req_data[g], ptr←(g+1) mod NREQ.
  - With no grant: stage_valid←0 and ptr is unchanged.
- Latency:
  - Request accepted at edge N (end of cycle N).
  - reg_d carries the new data during cycle N+1.
  - The register Q updates at edge N+1 and is visible from cycle N+2.
- reg_d (combinational): for each k, reg_d[k] = (stage_valid && stage_addr==k) ? stage_data : reg_q[k].
- pend_mask = stage_valid ? (1<<stage_addr) : 0. wr_busy = stage_valid.
- Boundary conditions:
  - Losing requesters hold valid/addr/data stable until granted; the bench checks this and the RTL need not buffer.
  - Two requesters targeting the same register: both are written in grant order, one cycle apart. The last granted write wins.
  - Back-to-back writes to the same register: the second write's data overwrites on the next edge, with no bubble.
  - Pointer wrap: ptr=NREQ-1 with grant g=NREQ-1 gives ptr=0.
  - An out-of-range req_addr cannot occur (AW=clog2(NREGS)); for non-power-of-2 NREGS, an addr ≥ NREGS is accepted and dropped (no reg_d change, pend_mask=0).
  - Reset asserted mid-write: the stage is cleared immediately, the in-flight write is lost, and reg_d returns to pass-through in the same cycle.
  - Fairness: with all requesters continuously valid, each is granted exactly once every NREQ cycles.

Decomposition:
- Shared package (cpu_pkg):
  - WIDTH=16, NREGS=8, AW=3.
  - Requester index constants REQ_ALU=0, REQ_LD=1, REQ_IMM=2.
- One sub-module, rr_arbiter (NREQ param; inputs req and ptr; outputs one-hot gnt and encoded gnt_idx), is natural and reusable for a future memory-port arbiter.

Test Plan:
- Reset: hold rst=1 and drive reg_q=0x1111…8888 → req_ready=0, pend_mask=0, reg_d==reg_q. Deassert rst and idle 3 cycles → no change.
- Single write: req 0 writes addr 3, data 0xBEEF → req_ready=001 in the request cycle; next cycle pend_mask=0x08, reg_d[3]=0xBEEF, all other reg_d slots equal reg_q; r4 Q=0xBEEF two cycles after acceptance.
- All three requesters valid for 6 cycles (addrs 1/2/5, data 0xA000/0xB000/0xC000) → grant order 0,1,2,0,1,2 and final registers r2=0xA000, r3=0xB000, r6=0xC000.
- Same-register conflict: req 1 and req 2 both target addr 7 (0x1234, 0x5678) with ptr=2 → req 2 is granted first, then req 1; final r8=0x1234.
- Async reset mid-write: assert rst between edges while stage_valid=1 → wr_busy and pend_mask drop to 0 with no clock edge, and the target register keeps its old value.
- Pointer wrap and idle: grant req 2 → ptr=0. Idle 2 cycles → ptr stays 0. Next, req 0 and req 1 both valid → req 0 is granted.

Source files
------------

// File: rtl/cpu_pkg.sv
// ============================================================================
// Module      : cpu_pkg
// Description : Shared register-file geometry, requester ids and helpers.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_pkg;

  localparam int WIDTH = 16;
  localparam int NREGS = 8;
  localparam int AW    = 3;

  localparam int REQ_ALU = 0;
  localparam int REQ_LD  = 1;
  localparam int REQ_IMM = 2;

  // Round-robin successor of idx in a ring of n slots.
  function automatic int rr_next(input int idx, input int n);
    return (idx >= n - 1) ? 0 : idx + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin arbiter; search starts at ptr.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter
  import cpu_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [PW-1:0]   gnt_idx
);

  always_comb begin
    logic found;
    int   idx;
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int i = 0; i < NREQ; i++) begin
      idx = (int'(ptr) + i) % NREQ;
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx  = PW'(idx);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/reg_write_arbiter.sv
// ============================================================================
// Module      : reg_write_arbiter
// Description : Round-robin shared write port into the register block with a
//               single registered write stage and pending-write mask.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_write_arbiter
  import cpu_pkg::*;
#(
  parameter int NREQ  = 3,
  parameter int NREGS = cpu_pkg::NREGS,
  parameter int WIDTH = cpu_pkg::WIDTH,
  parameter int AW    = cpu_pkg::AW
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*AW-1:0]     req_addr,
  input  logic [NREQ*WIDTH-1:0]  req_data,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREGS*WIDTH-1:0] reg_q,
  output logic [NREGS*WIDTH-1:0] reg_d,
  output logic [NREGS-1:0]       pend_mask,
  output logic                   wr_busy
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic             stage_valid;
  logic [AW-1:0]    stage_addr;
  logic [WIDTH-1:0] stage_data;
  logic [PW-1:0]    ptr;
  logic [NREQ-1:0]  gnt;
  logic [PW-1:0]    gnt_idx;
  logic             accept;

  rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_arb (
    .req     (req_valid),
    .ptr     (ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  // Grants are suppressed while reset is held so nothing looks accepted.
  assign req_ready = rst ? '0 : gnt;
  assign accept    = |gnt;
  assign wr_busy   = stage_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_valid <= 1'b0;
      stage_addr  <= '0;
      stage_data  <= '0;
      ptr         <= '0;
    end else begin
      stage_valid <= accept;
      if (accept) begin
        stage_addr <= req_addr[int'(gnt_idx)*AW +: AW];
        stage_data <= req_data[int'(gnt_idx)*WIDTH +: WIDTH];
        ptr        <= PW'(rr_next(int'(gnt_idx), NREQ));
      end
    end
  end

  // An address with no matching slot simply falls through every compare.
  for (genvar k = 0; k < NREGS; k++) begin : g_slot
    logic hit;
    assign hit                       = stage_valid && (stage_addr == AW'(k));
    assign pend_mask[k]              = hit;
    assign reg_d[k*WIDTH +: WIDTH]   = hit ? stage_data : reg_q[k*WIDTH +: WIDTH];
  end

endmodule

`default_nettype wire

// File: tb/tb_reg_write_arbiter.sv
// ============================================================================
// Module      : tb_reg_write_arbiter
// Description : Table-driven bench with a behavioural register block model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_reg_write_arbiter;

  localparam int NREQ = 3, NREGS = 8, WIDTH = 16, AW = 3;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [NREQ-1:0]        req_valid;
  logic [NREQ*AW-1:0]     req_addr;
  logic [NREQ*WIDTH-1:0]  req_data;
  logic [NREQ-1:0]        req_ready;
  logic [NREGS*WIDTH-1:0] reg_q;
  logic [NREGS*WIDTH-1:0] reg_d;
  logic [NREGS-1:0]       pend_mask;
  logic                   wr_busy;

  logic [WIDTH-1:0] regs [NREGS];
  int n_cmp = 0;
  int n_bad = 0;

  reg_write_arbiter #(.NREQ(NREQ), .NREGS(NREGS), .WIDTH(WIDTH), .AW(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_ready (req_ready),
    .reg_q     (reg_q),
    .reg_d     (reg_d),
    .pend_mask (pend_mask),
    .wr_busy   (wr_busy)
  );

  always #5 clk = ~clk;

  // Register block: reloads D every edge, r1 at the LSBs.
  initial for (int k = 0; k < NREGS; k++) regs[k] = 16'(k + 1) * 16'h1111;
  always @(posedge clk) for (int k = 0; k < NREGS; k++) regs[k] <= reg_d[k*WIDTH +: WIDTH];
  always_comb for (int k = 0; k < NREGS; k++) reg_q[k*WIDTH +: WIDTH] = regs[k];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  typedef struct {
    logic [2:0]  valid;
    logic [8:0]  addr;
    logic [47:0] data;
    logic [2:0]  ready;
    logic [7:0]  pend;
    logic [15:0] wd;
  } vec_t;

  vec_t tbl [29];

  function automatic vec_t mk(input logic [2:0] v, input logic [2:0] a0, a1, a2,
                              input logic [15:0] d0, d1, d2,
                              input logic [2:0] r, input logic [7:0] p,
                              input logic [15:0] wd);
    vec_t t;
    t.valid = v; t.addr = {a2, a1, a0}; t.data = {d2, d1, d0};
    t.ready = r; t.pend = p; t.wd = wd;
    return t;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] exp_regd(input logic [7:0] p, input logic [15:0] wd);
    logic [127:0] r;
    for (int k = 0; k < NREGS; k++) r[k*WIDTH +: WIDTH] = p[k] ? wd : regs[k];
    return r;
  endfunction

  logic [15:0] final_exp [NREGS];

  initial begin
    // single write, then wrap via req 2 and two idle cycles
    tbl[0]  = mk(3'b001, 3, 0, 0, 16'hBEEF, 0, 0,      3'b001, 8'h00, 16'h0);
    tbl[1]  = mk(3'b000, 0, 0, 0, 0, 0, 0,             3'b000, 8'h08, 16'hBEEF);
    tbl[2]  = mk(3'b100, 0, 0, 0, 0, 0, 16'h00C3,      3'b100, 8'h00, 16'h0);
    tbl[3]  = mk(3'b000, 0, 0, 0, 0, 0, 0,             3'b000, 8'h01, 16'h00C3);
    tbl[4]  = mk(3'b000, 0, 0, 0, 0, 0, 0,             3'b000, 8'h00, 16'h0);
    // all three valid for six cycles from ptr=0
    tbl[5]  = mk(3'b111, 1, 2, 5, 16'hA000, 16'hB000, 16'hC000, 3'b001, 8'h00, 16'h0);
    tbl[6]  = mk(3'b111, 1, 2, 5, 16'hA000, 16'hB000, 16'hC000, 3'b010, 8'h02, 16'hA000);
    tbl[7]  = mk(3'b111, 1, 2, 5, 16'hA000, 16'hB000, 16'hC000, 3'b100, 8'h04, 16'hB000);
    tbl[8]  = mk(3'b111, 1, 2, 5, 16'hA000, 16'hB000, 16'hC000, 3'b001, 8'h20, 16'hC000);
    tbl[9]  = mk(3'b111, 1, 2, 5, 16'hA000, 16'hB000, 16'hC000, 3'b010, 8'h02, 16'hA000);
    tbl[10] = mk(3'b111, 1, 2, 5, 16'hA000, 16'hB000, 16'hC000, 3'b100, 8'h04, 16'hB000);
    tbl[11] = mk(3'b000, 0, 0, 0, 0, 0, 0,             3'b000, 8'h20, 16'hC000);
    tbl[12] = mk(3'b000, 0, 0, 0, 0, 0, 0,             3'b000, 8'h00, 16'h0);
    // move ptr to 2, then same-register conflict on r8
    tbl[13] = mk(3'b010, 0, 0, 0, 0, 16'h0111, 0,      3'b010, 8'h00, 16'h0);
    tbl[14] = mk(3'b110, 0, 7, 7, 0, 16'h1234, 16'h5678, 3'b100, 8'h01, 16'h0111);
    tbl[15] = mk(3'b010, 0, 7, 0, 0, 16'h1234, 0,      3'b010, 8'h80, 16'h5678);
    tbl[16] = mk(3'b000, 0, 0, 0, 0, 0, 0,             3'b000, 8'h80, 16'h1234);
    tbl[17] = mk(3'b000, 0, 0, 0, 0, 0, 0,             3'b000, 8'h00, 16'h0);
    // back-to-back writes to r5
    tbl[18] = mk(3'b001, 4, 0, 0, 16'h1111, 0, 0,      3'b001, 8'h00, 16'h0);
    tbl[19] = mk(3'b010, 0, 4, 0, 0, 16'h2222, 0,      3'b010, 8'h10, 16'h1111);
    tbl[20] = mk(3'b000, 0, 0, 0, 0, 0, 0,             3'b000, 8'h10, 16'h2222);
    tbl[21] = mk(3'b000, 0, 0, 0, 0, 0, 0,             3'b000, 8'h00, 16'h0);
    // wrap from ptr=2, idle, then req 0 beats req 1
    tbl[22] = mk(3'b100, 0, 0, 6, 0, 0, 16'h6666,      3'b100, 8'h00, 16'h0);
    tbl[23] = mk(3'b000, 0, 0, 0, 0, 0, 0,             3'b000, 8'h40, 16'h6666);
    tbl[24] = mk(3'b000, 0, 0, 0, 0, 0, 0,             3'b000, 8'h00, 16'h0);
    tbl[25] = mk(3'b011, 0, 1, 0, 16'h0AAA, 16'h0BBB, 0, 3'b001, 8'h00, 16'h0);
    tbl[26] = mk(3'b010, 0, 1, 0, 0, 16'h0BBB, 0,      3'b010, 8'h01, 16'h0AAA);
    tbl[27] = mk(3'b000, 0, 0, 0, 0, 0, 0,             3'b000, 8'h02, 16'h0BBB);
    tbl[28] = mk(3'b000, 0, 0, 0, 0, 0, 0,             3'b000, 8'h00, 16'h0);

    final_exp = '{16'h0AAA, 16'h0BBB, 16'hB000, 16'hBEEF,
                  16'h2222, 16'hC000, 16'h6666, 16'h1234};

    // reset with requests pending must not grant
    rst = 1'b1; req_valid = 3'b111; req_addr = '0; req_data = '0;
    #2;
    chk("rst_ready", 128'(req_ready), 128'(3'b000));
    chk("rst_pend",  128'(pend_mask), 128'(8'h00));
    chk("rst_busy",  128'(wr_busy),   128'(1'b0));
    chk("rst_regd",  reg_d, reg_q);
    @(negedge clk); req_valid = '0;
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #2;
      chk("idle_pend", 128'(pend_mask), 128'(8'h00));
      chk("idle_regd", reg_d, reg_q);
    end

    for (int i = 0; i < 29; i++) begin
      @(negedge clk);
      req_valid = tbl[i].valid; req_addr = tbl[i].addr; req_data = tbl[i].data;
      #2;
      chk($sformatf("v%0d_ready", i), 128'(req_ready), 128'(tbl[i].ready));
      chk($sformatf("v%0d_pend", i),  128'(pend_mask), 128'(tbl[i].pend));
      chk($sformatf("v%0d_busy", i),  128'(wr_busy),   128'(tbl[i].pend != 8'h00));
      chk($sformatf("v%0d_regd", i),  reg_d, exp_regd(tbl[i].pend, tbl[i].wd));
      if (i == 2) chk("r4_after_write", 128'(regs[3]), 128'(16'hBEEF));
    end

    // async reset while a write to r3 is in flight
    @(negedge clk);
    req_valid = 3'b001; req_addr = 9'd2; req_data = 48'h0000_0000_DEAD;
    @(posedge clk); #1;
    req_valid = '0;
    chk("mid_busy", 128'(wr_busy),   128'(1'b1));
    chk("mid_pend", 128'(pend_mask), 128'(8'h04));
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_busy", 128'(wr_busy),   128'(1'b0));
    chk("mid_rst_pend", 128'(pend_mask), 128'(8'h00));
    chk("mid_rst_regd", reg_d, reg_q);
    @(negedge clk); rst = 1'b0;
    @(negedge clk); #2;
    chk("mid_rst_r3", 128'(regs[2]), 128'(16'hB000));

    for (int k = 0; k < NREGS; k++)
      chk($sformatf("final_r%0d", k + 1), 128'(regs[k]), 128'(final_exp[k]));

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
